// File: rtl/do_grayscale_conversion_if.sv
// Frame-buffer 2 port bundle: one read address/data pair and one write port.
interface do_grayscale_conversion_if #(
  parameter int unsigned ADDR_W = 17
);
  logic [ADDR_W-1:0] rdaddr_o;
  logic [11:0]       din_i;
  logic [ADDR_W-1:0] wraddr_o;
  logic [11:0]       dout_o;
  logic              we_o;

  modport master (output rdaddr_o, wraddr_o, dout_o, we_o, input din_i);
  modport slave  (input rdaddr_o, wraddr_o, dout_o, we_o, output din_i);
endinterface

// File: rtl/do_grayscale_conversion.sv
// In-place RGB444 -> grayscale pass over frame buffer 2; each word rewritten as {Y,Y,Y}.
module do_grayscale_conversion #(
  parameter int unsigned NUM_PIXELS = 76800,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic busy_o,
  output logic done_o,
  do_grayscale_conversion_if.master buf_if
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              iss_v_q, iss_v_d;
  logic [1:0]        drn_q, drn_d;
  logic              start;

  logic [RD_LAT-1:0] sh_v;
  logic [ADDR_W-1:0] sh_a [RD_LAT];
  logic              we_q;
  logic [ADDR_W-1:0] wraddr_q;
  logic [11:0]       dout_q;
  logic [11:0]       sum;
  logic [3:0]        y;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      iss_v_q  <= 1'b0;
      drn_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      iss_v_q  <= iss_v_d;
      drn_q    <= drn_d;
    end
  end

  // iss_v marks the cycle in which rdaddr_o carries a fresh read for this frame
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    iss_v_d  = 1'b0;
    drn_d    = drn_q;
    start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d  = RUN;
          rd_cnt_d = '0;
          iss_v_d  = 1'b1;
          start    = 1'b1;
        end
      end
      RUN: begin
        if (rd_cnt_q == LAST_ADDR) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          iss_v_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == DRAIN_LAST) state_d = DONE;
        else                     drn_d   = drn_q + 1'b1;
      end
      DONE: begin
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum = 12'd77  * {8'd0, buf_if.din_i[11:8]}
        + 12'd150 * {8'd0, buf_if.din_i[7:4]}
        + 12'd29  * {8'd0, buf_if.din_i[3:0]};
    y   = 4'(sum >> 8);
  end

  // Valid/address shadow the buffer read latency so stage E sees the matching address
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_v     <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) sh_a[i] <= '0;
      we_q     <= 1'b0;
      wraddr_q <= '0;
      dout_q   <= '0;
    end else begin
      sh_v[0] <= iss_v_q & ~start;
      sh_a[0] <= rd_cnt_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        sh_v[i] <= sh_v[i-1] & ~start;
        sh_a[i] <= sh_a[i-1];
      end
      we_q <= sh_v[RD_LAT-1] & ~start;
      if (sh_v[RD_LAT-1]) begin
        wraddr_q <= sh_a[RD_LAT-1];
        dout_q   <= {y, y, y};
      end
    end
  end

  assign buf_if.rdaddr_o = rd_cnt_q;
  assign buf_if.wraddr_o = wraddr_q;
  assign buf_if.dout_o   = dout_q;
  assign buf_if.we_o     = we_q;
  assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
  assign done_o          = (state_q == DONE);

endmodule
